// File: rtl/fifo_stream_arbiter_pkg.sv
// Shared types and sizing helpers for the stream FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    NEW,
    STREAM
  } arb_state_e;

  // One extra bit so the occupancy mirror can represent a completely full FIFO.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the priority pointer.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   prio_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  int   j;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(prio_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_stream_arbiter.sv
// Write-side controller for the shared stream FIFO: locks one producer per stream,
// waits for the FIFO to drain, pulses new-stream, then forwards words with backpressure.
module fifo_stream_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_rd_en_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_new_stream_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          stream_done_o,
  output logic [LEN_WIDTH-1:0]          stream_len_o
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     prio_q;
  logic [OCC_W-1:0]     occ_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] stream_len_q;
  logic                 done_q;
  logic                 new_stream_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 in_stream;
  logic                 has_room;
  logic                 accept;
  logic                 rd_eff;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_WIDTH'(1);
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .valid_i (req_valid_i),
    .prio_i  (prio_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  always_comb begin
    in_stream    = (state_q == STREAM);
    has_room     = (occ_q < OCC_FULL);
    accept       = in_stream && has_room && req_valid_i[gidx_q];
    rd_eff       = fifo_rd_en_i && (occ_q != '0);
    req_ready_o  = (in_stream && has_room) ? grant_q : '0;
    fifo_wr_en_o = accept;
    fifo_data_o  = (|grant_q) ? req_data_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign fifo_new_stream_o = new_stream_q;
  assign grant_o           = grant_q;
  assign busy_o            = (state_q != IDLE);
  assign stream_done_o     = done_q;
  assign stream_len_o      = stream_len_q;

  // Occupancy mirror; a read with nothing stored is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else if (accept && !rd_eff) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!accept && rd_eff) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      prio_q       <= '0;
      len_q        <= '0;
      stream_len_q <= '0;
      done_q       <= 1'b0;
      new_stream_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      new_stream_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q <= arb_grant;
            gidx_q  <= arb_idx;
            state_q <= WAIT_DRAIN;
          end
        end
        WAIT_DRAIN: begin
          if (occ_q == '0) begin
            new_stream_q <= 1'b1;
            state_q      <= NEW;
          end
        end
        NEW: begin
          len_q   <= '0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            len_q <= sat_inc(len_q);
            if (req_last_i[gidx_q]) begin
              state_q      <= IDLE;
              grant_q      <= '0;
              stream_len_q <= sat_inc(len_q);
              done_q       <= 1'b1;
              prio_q       <= (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_stream_arbiter.md
# fifo_stream_arbiter

Write-side controller for the shared variable-length stream FIFO. It round-robin arbitrates NUM_REQ producers and locks the grant for one whole stream (first word to `last`). Before each stream it waits until the consumer has drained the FIFO, then pulses the FIFO's new-stream input. It sits between the producer ports and the FIFO's `wr_en`/`new_stream_i`/`data_i` pins.

## Interface
- NUM_REQ, 4, number of producers (≥2)
- DATA_WIDTH, 8, word width; must match FIFO
- DEPTH, 16, FIFO depth; must match FIFO
- LEN_WIDTH, 16, width of stream length counter
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-producer word valid
- req_last_i  in  NUM_REQ  per-producer last-word-of-stream flag
- req_data_i  in  NUM_REQ*DATA_WIDTH  producer words, producer i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NUM_REQ  per-producer accept; a word transfers when valid && ready
- fifo_rd_en_i  in  1  consumer read strobe (same net as FIFO `rd_en`), observed only
- fifo_wr_en_o  out  1  FIFO write enable
- fifo_data_o  out  DATA_WIDTH  FIFO write data
- fifo_new_stream_o  out  1  FIFO pointer-clear pulse
- grant_o  out  NUM_REQ  one-hot current grant, 0 when none
- busy_o  out  1  state ≠ IDLE
- stream_done_o  out  1  one-cycle pulse after a stream's last word is accepted
- stream_len_o  out  LEN_WIDTH  word count of the most recently completed stream

## Operation
- FSM states: IDLE, WAIT_DRAIN, NEW, STREAM.
- IDLE: if any req_valid_i, rr_arbiter picks the first valid at or after priority pointer `prio`. Next edge: latch grant, go to WAIT_DRAIN.
- WAIT_DRAIN: stay until occ == 0, then go to NEW.
- NEW: fifo_new_stream_o = 1 for exactly one cycle. Clear len counter. Go to STREAM.
- STREAM: req_ready_o[g] = (occ < DEPTH); all other ready bits are 0. fifo_wr_en_o = req_valid_i[g] && req_ready_o[g]. fifo_data_o = granted word (combinational mux). Each accept increments len.
- STREAM end: on accept with req_last_i[g], next edge does all of the following: go to IDLE, grant := 0, stream_len_o := len+1, stream_done_o := 1, prio := (g+1) mod NUM_REQ.
- Grant is held while the granted producer deasserts valid mid-stream. No timeout.
- occ is an internal occupancy mirror, width clog2(DEPTH)+1. It counts +1 on write, −1 on fifo_rd_en_i when occ > 0, and is unchanged on a simultaneous write and read. FIFO empty/full flags are not used.
- A read with occ == 0 is ignored (no underflow).
- The len counter saturates at 2^LEN_WIDTH−1.
- fifo_data_o = 0 when there is no grant.

## Timing
- Reset (async): state IDLE, grant_o 0, prio 0, occ 0, len 0.
- Reset values of outputs: req_ready_o 0, fifo_wr_en_o 0, fifo_data_o 0, fifo_new_stream_o 0, busy_o 0, stream_done_o 0, stream_len_o 0.
- Reset mid-stream aborts the stream immediately. No new_stream pulse is issued.
- Minimum latency with occ == 0: valid in cycle 0 → grant in cycle 1 → new_stream pulse in cycle 2 → first ready in cycle 3.
- fifo_new_stream_o is never asserted in the same cycle as fifo_wr_en_o.
- In STREAM, throughput is one word per cycle while occ < DEPTH. When occ == DEPTH, ready drops the same cycle. A read in that cycle re-enables ready the next cycle.
- The minimum gap between streams is 1 IDLE cycle.
- stream_done_o is asserted in that IDLE cycle. The next arbitration can occur in the same cycle.
- A single-word stream (valid && last on the first word) completes in 1 STREAM cycle.

## Structure
- Package fifo_arb_pkg holds: the state enum typedef (IDLE, WAIT_DRAIN, NEW, STREAM) and a helper function for the occupancy width constant.
- Sub-module rr_arbiter (combinational): inputs valid vector and prio; outputs one-hot grant and index. Instantiated once.
- The top level holds the FSM, the occ/len counters, and the data mux.

## Test plan
- NUM_REQ=4, DEPTH=16. Reset, then req 2 sends 3 words 0xA1,0xA2,0xA3 (last on 0xA3), consumer idle → new_stream pulse in cycle 2, ready from cycle 3, 3 writes, stream_done_o with stream_len_o=3, prio=3.
- Req 0 and req 3 valid together with prio=3 → req 3 granted first. After its stream, req 0 is granted. Ready is never seen on a non-granted port.
- 20-word stream, consumer idle → ready drops after 16 writes (occ=16). A single fifo_rd_en_i pulse → exactly 1 more write accepted.
- Stream ends with occ=5, req 1 pending → stays in WAIT_DRAIN until 5 reads complete, then new_stream pulse, then stream.
- Simultaneous write and read for 10 cycles at occ=8 → occ stays 8, ready stays high.
- Assert rst_ni low mid-stream (occ=7) → all outputs 0 asynchronously. After release, IDLE with prio 0 and occ 0.
